solver_scheduler: RTL and testbench
===================================

Name: solver_scheduler

Overview:
- Round-robin scheduler that shares NUM_SOLVERS parallel machine-configuration solver instances among the stream of parsed Day 10 machine records.
- Sits between the input reader (job source) and the output writer (result sink).
- Replaces the single-solver read/configure/write sequencing with overlapped solving.
- Results retire in exactly the order jobs were accepted.

Parameters:
- NUM_SOLVERS, 4, number of solver instances; ≥2.
- JOB_WIDTH, 64, bits of one parsed machine record (light target plus button masks).
- RESULT_WIDTH, 16, bits of one solver result (minimum press count).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- job_valid  input  1  job_data/job_last valid.
- job_ready  output  1  scheduler accepts the job this cycle.
- job_data  input  JOB_WIDTH  parsed machine record.
- job_last  input  1  marks the final job of the input.
- solver_start  output  NUM_SOLVERS  one-cycle start pulse per solver.
- solver_job  output  NUM_SOLVERS*JOB_WIDTH  per-solver registered job; slice i drives solver i.
- solver_done  input  NUM_SOLVERS  one-cycle completion pulse per solver.
- solver_result  input  NUM_SOLVERS*RESULT_WIDTH  per-solver result; valid with solver_done[i].
- res_valid  output  1  result available.
- res_ready  input  1  sink accepts the result.
- res_data  output  RESULT_WIDTH  result, in job order.
- res_last  output  1  result belongs to the job_last job.
- busy_count  output  $clog2(NUM_SOLVERS+1)  number of non-IDLE slots.
- all_done  output  1  sticky; last result retired.
- protocol_err  output  1  sticky; unexpected solver_done.

Behaviour:
- Reset: synchronous, active-high, sampled on posedge clk.
  - All slots go IDLE; dp=rp=0; last_seen=0.
  - Every output is 0: job_ready, solver_start, solver_job, res_valid, res_data, res_last, busy_count, all_done, protocol_err.
  - Reset mid-operation discards every in-flight job and result; solvers share the same rst.
- Per-slot state (one slot per solver): IDLE -> BUSY -> DONE -> IDLE.
  - Each slot also holds job_reg, result_reg and last_reg.
- Dispatch pointer dp and retire pointer rp are each $clog2(NUM_SOLVERS) bits and wrap from NUM_SOLVERS-1 to 0.
- job_ready is combinational: slot[dp]==IDLE && !last_seen && !all_done. It does not depend on job_valid.
- Accept happens on job_valid && job_ready at cycle T. On that edge:
  - solver_job[dp] <= job_data and last_reg[dp] <= job_last.
  - slot goes BUSY; dp increments.
  - last_seen <= job_last.
  - solver_start[dp_old] is registered: high during cycle T+1 for exactly one cycle.
  - solver_job slice stays stable until the next dispatch to that slot.
- Completion: solver_done[i] high while slot i is BUSY and solver_start[i] is low.
  - Effect: result_reg[i] <= solver_result slice i and slot goes DONE.
  - res_valid can rise at the earliest the cycle after solver_done.
- Ignored done: solver_done[i] while slot i is IDLE or DONE, or coincident with solver_start[i].
  - The pulse is ignored and protocol_err is set (sticky).
- Retire outputs: res_valid = slot[rp]==DONE; res_data = result_reg[rp]; res_last = last_reg[rp]. All are driven from registers with no combinational path from res_ready.
- Retire on res_valid && res_ready:
  - slot[rp] goes IDLE and rp increments.
  - If res_last is set, all_done <= 1 (sticky until rst).
- Ordering: dispatch and retire are both strict round-robin, so results complete out of order but retire in order.
  - A DONE slot that is not at rp waits.
  - res_valid stays low while slot[rp] is BUSY, even if other slots are DONE.
- Simultaneous events in one cycle (dispatch, completion of another slot, retire) are all legal and independent.
  - A slot retired this cycle is not dispatchable until the next cycle (one-cycle bubble, by design).
- Full: every slot non-IDLE gives job_ready=0 and busy_count=NUM_SOLVERS.
- Empty: busy_count=0 gives res_valid=0.
- After job_last is accepted, job_ready stays 0 until rst. Additional job_valid is ignored.
- busy_count is registered and is updated on the same edge as the slot-state changes.

Test Plan:
- Single job (NUM_SOLVERS=4): accept at T with job_last=1, job_data=0x1234.
  - solver_start=4'b0001 at T+1; solver_job[0]=0x1234; job_ready=0 from T+1.
  - solver_done[0] at T+5 with result 7 -> res_valid, res_data=7, res_last=1 at T+6.
  - Retire -> all_done=1 next cycle; busy_count 1 -> 0.
- Out-of-order completion: 4 jobs with results 3,5,2,9; done order solver 2,3,0,1.
  - res_data sequence is exactly 3,5,2,9.
  - res_valid stays low until solver 0 completes.
- Full/backpressure: 4 jobs in flight, res_ready=0 -> job_ready=0, busy_count=4.
  - Fifth job_valid held until one retire plus one cycle, then dispatched to slot 0 (wrap).
- Spurious done: solver_done[2] while slot 2 IDLE -> protocol_err=1 sticky; results unaffected.
- Reset mid-operation: rst with 3 slots BUSY -> all outputs 0 next cycle.
  - A new job after reset dispatches to solver 0.
- Stream of 10 jobs, random solver latency 1–20, res_ready toggling 50%.
  - 10 results in order; only the 10th has res_last; all_done after it.

Source files
------------

// File: rtl/solver_scheduler.sv
// -----------------------------------------------------------------------------
// solver_scheduler
//
// Shares NUM_SOLVERS machine-configuration solver instances among a stream of
// parsed machine records. Jobs are dispatched round-robin to free solver slots.
// Results are collected as the solvers finish, in any order, and are released
// to the sink strictly in the order the jobs were accepted.
//
// Ports
//   clk            clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   job_valid      job source presents job_data/job_last
//   job_ready      scheduler accepts the presented job this cycle
//   job_data       parsed machine record
//   job_last       marks the final job of the input
//   solver_start   one-cycle start pulse per solver
//   solver_job     registered job per solver (slice i drives solver i)
//   solver_done    one-cycle completion pulse per solver
//   solver_result  per-solver result, valid together with solver_done[i]
//   res_valid      a result is available at the retire pointer
//   res_ready      sink accepts the result
//   res_data       result, in job order
//   res_last       result belongs to the job marked job_last
//   busy_count     number of slots that are not IDLE
//   all_done       sticky, the last result has been retired
//   protocol_err   sticky, a solver_done pulse arrived when none was expected
// -----------------------------------------------------------------------------
module solver_scheduler #(
    parameter int NUM_SOLVERS  = 4,
    parameter int JOB_WIDTH    = 64,
    parameter int RESULT_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 job_valid,
    output logic                                 job_ready,
    input  logic [JOB_WIDTH-1:0]                 job_data,
    input  logic                                 job_last,
    output logic [NUM_SOLVERS-1:0]               solver_start,
    output logic [NUM_SOLVERS*JOB_WIDTH-1:0]     solver_job,
    input  logic [NUM_SOLVERS-1:0]               solver_done,
    input  logic [NUM_SOLVERS*RESULT_WIDTH-1:0]  solver_result,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [RESULT_WIDTH-1:0]              res_data,
    output logic                                 res_last,
    output logic [$clog2(NUM_SOLVERS+1)-1:0]     busy_count,
    output logic                                 all_done,
    output logic                                 protocol_err
);

    localparam int PTR_W = $clog2(NUM_SOLVERS);
    localparam int CNT_W = $clog2(NUM_SOLVERS + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_SOLVERS - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } slot_state_e;

    // Per-slot state and storage
    slot_state_e               slot_q   [NUM_SOLVERS];
    slot_state_e               slot_d   [NUM_SOLVERS];
    logic [JOB_WIDTH-1:0]      job_q    [NUM_SOLVERS];
    logic [JOB_WIDTH-1:0]      job_d    [NUM_SOLVERS];
    logic [RESULT_WIDTH-1:0]   result_q [NUM_SOLVERS];
    logic [RESULT_WIDTH-1:0]   result_d [NUM_SOLVERS];
    logic [NUM_SOLVERS-1:0]    last_q;
    logic [NUM_SOLVERS-1:0]    last_d;
    logic [NUM_SOLVERS-1:0]    start_q;
    logic [NUM_SOLVERS-1:0]    start_d;

    // Global pointers and flags
    logic [PTR_W-1:0]          dp_q;
    logic [PTR_W-1:0]          dp_d;
    logic [PTR_W-1:0]          rp_q;
    logic [PTR_W-1:0]          rp_d;
    logic                      last_seen_q;
    logic                      last_seen_d;
    logic                      all_done_q;
    logic                      all_done_d;
    logic                      err_q;
    logic                      err_d;
    logic [CNT_W-1:0]          busy_q;
    logic [CNT_W-1:0]          busy_d;

    logic                      job_ready_s;
    logic                      accept_s;
    logic                      retire_s;
    logic                      res_valid_s;

    // Round-robin pointer advance with explicit wrap (works for any slot count).
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_LAST) begin
            n = '0;
        end else begin
            n = p + PTR_ONE;
        end
        return n;
    endfunction

    // Ready depends only on registered state; held low while rst is asserted
    // so every output reads zero during reset.
    assign job_ready_s = !rst && (slot_q[dp_q] == S_IDLE) && !last_seen_q && !all_done_q;
    assign res_valid_s = (slot_q[rp_q] == S_DONE);
    assign accept_s    = job_valid && job_ready_s;
    assign retire_s    = res_valid_s && res_ready;

    assign job_ready    = job_ready_s;
    assign res_valid    = res_valid_s;
    assign res_data     = result_q[rp_q];
    assign res_last     = last_q[rp_q];
    assign solver_start = start_q;
    assign busy_count   = busy_q;
    assign all_done     = all_done_q;
    assign protocol_err = err_q;

    genvar g;
    generate
        for (g = 0; g < NUM_SOLVERS; g++) begin : g_job_out
            assign solver_job[g*JOB_WIDTH +: JOB_WIDTH] = job_q[g];
        end
    endgenerate

    // Next-state: completion, retire and dispatch touch disjoint slots
    // (BUSY, DONE at rp, IDLE at dp), so they are evaluated independently.
    always_comb begin
        slot_d      = slot_q;
        job_d       = job_q;
        result_d    = result_q;
        last_d      = last_q;
        start_d     = '0;
        dp_d        = dp_q;
        rp_d        = rp_q;
        last_seen_d = last_seen_q;
        all_done_d  = all_done_q;
        err_d       = err_q;
        busy_d      = '0;

        // Completion: accepted only from a BUSY slot whose start pulse is over.
        for (int i = 0; i < NUM_SOLVERS; i++) begin
            if (solver_done[i]) begin
                if ((slot_q[i] == S_BUSY) && !start_q[i]) begin
                    result_d[i] = solver_result[i*RESULT_WIDTH +: RESULT_WIDTH];
                    slot_d[i]   = S_DONE;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                result_d[i] = result_q[i];
            end
        end

        // Retire the in-order head; the freed slot is only seen as IDLE next cycle.
        if (retire_s) begin
            slot_d[rp_q] = S_IDLE;
            rp_d         = next_ptr(rp_q);
            if (last_q[rp_q]) begin
                all_done_d = 1'b1;
            end else begin
                all_done_d = all_done_q;
            end
        end else begin
            rp_d = rp_q;
        end

        // Dispatch to the slot at dp and schedule its one-cycle start pulse.
        if (accept_s) begin
            slot_d[dp_q]  = S_BUSY;
            job_d[dp_q]   = job_data;
            last_d[dp_q]  = job_last;
            start_d[dp_q] = 1'b1;
            dp_d          = next_ptr(dp_q);
            last_seen_d   = job_last;
        end else begin
            dp_d = dp_q;
        end

        // Occupancy is taken from the next state so it moves with the slots.
        for (int i = 0; i < NUM_SOLVERS; i++) begin
            if (slot_d[i] != S_IDLE) begin
                busy_d = busy_d + CNT_ONE;
            end else begin
                busy_d = busy_d;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SOLVERS; i++) begin
                slot_q[i]   <= S_IDLE;
                job_q[i]    <= '0;
                result_q[i] <= '0;
            end
            last_q      <= '0;
            start_q     <= '0;
            dp_q        <= '0;
            rp_q        <= '0;
            last_seen_q <= 1'b0;
            all_done_q  <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= '0;
        end else begin
            for (int i = 0; i < NUM_SOLVERS; i++) begin
                slot_q[i]   <= slot_d[i];
                job_q[i]    <= job_d[i];
                result_q[i] <= result_d[i];
            end
            last_q      <= last_d;
            start_q     <= start_d;
            dp_q        <= dp_d;
            rp_q        <= rp_d;
            last_seen_q <= last_seen_d;
            all_done_q  <= all_done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_solver_scheduler.sv
module tb_solver_scheduler;

    localparam int N  = 4;
    localparam int JW = 64;
    localparam int RW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              job_valid;
    logic              job_ready;
    logic [JW-1:0]     job_data;
    logic              job_last;
    logic [N-1:0]      solver_start;
    logic [N*JW-1:0]   solver_job;
    logic [N-1:0]      solver_done;
    logic [N*RW-1:0]   solver_result;
    logic              res_valid;
    logic              res_ready;
    logic [RW-1:0]     res_data;
    logic              res_last;
    logic [2:0]        busy_count;
    logic              all_done;
    logic              protocol_err;

    // Solver stand-ins: manual pulses for directed tests, a latency model otherwise.
    logic              auto_mode = 1'b0;
    logic [N-1:0]      man_done = '0;
    logic [N-1:0]      auto_done = '0;
    logic [N*RW-1:0]   man_result = '0;
    logic [N*RW-1:0]   auto_result = '0;
    int                cnt [N];

    assign solver_done   = auto_mode ? auto_done : man_done;
    assign solver_result = auto_mode ? auto_result : man_result;

    typedef struct packed {
        logic [RW-1:0] data;
        logic          last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    solver_scheduler #(.NUM_SOLVERS(N), .JOB_WIDTH(JW), .RESULT_WIDTH(RW)) dut (
        .clk          (clk),
        .rst          (rst),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_data     (job_data),
        .job_last     (job_last),
        .solver_start (solver_start),
        .solver_job   (solver_job),
        .solver_done  (solver_done),
        .solver_result(solver_result),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_last     (res_last),
        .busy_count   (busy_count),
        .all_done     (all_done),
        .protocol_err (protocol_err)
    );

    function automatic logic [RW-1:0] model_result(input logic [JW-1:0] j);
        return j[RW-1:0] ^ 16'hA5C3;
    endfunction

    function automatic exp_t mk(input logic [RW-1:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        return e;
    endfunction

    // Latency model: a start pulse arms a random 1..20 cycle countdown.
    initial begin
        for (int i = 0; i < N; i++) cnt[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            auto_done = '0;
            for (int i = 0; i < N; i++) begin
                if (rst) begin
                    cnt[i] = 0;
                end else begin
                    if (cnt[i] > 0) begin
                        cnt[i] = cnt[i] - 1;
                        if (cnt[i] == 0) begin
                            auto_done[i] = 1'b1;
                            auto_result[i*RW +: RW] = model_result(solver_job[i*JW +: JW]);
                        end
                    end
                    if (auto_mode && solver_start[i]) cnt[i] = $urandom_range(20, 1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives rst high for two edges and leaves it asserted.
    task automatic start_reset();
        rst = 1'b1;
        job_valid = 1'b0;
        job_last = 1'b0;
        job_data = '0;
        res_ready = 1'b0;
        man_done = '0;
        man_result = '0;
        auto_mode = 1'b0;
        q.delete();
        step();
        step();
    endtask

    task automatic reset_and_release();
        start_reset();
        rst = 1'b0;
        step();
    endtask

    // Offers one job until accepted; ok reports whether it went in within the bound.
    task automatic send_job(input logic [JW-1:0] d, input logic l, output bit ok);
        job_data = d;
        job_last = l;
        job_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (job_ready) begin
                ok = 1'b1;
                step();
                break;
            end
            step();
        end
        job_valid = 1'b0;
        job_last = 1'b0;
    endtask

    task automatic test_reset();
        start_reset();
        checks++;
        if (job_ready !== 1'b0 || solver_start !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: job_ready=%b solver_start=%b, required 0/0000", job_ready, solver_start);
        end
        checks++;
        if (solver_job !== {(N*JW){1'b0}} || res_data !== 16'h0000 || busy_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_data: solver_job=%h res_data=%h busy=%0d, required zeros", solver_job, res_data, busy_count);
        end
        checks++;
        if ({res_valid, res_last, all_done, protocol_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: v/l/done/err=%b, required 0000", {res_valid, res_last, all_done, protocol_err});
        end
        rst = 1'b0;
        step();
        checks++;
        if (job_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", job_ready);
        end
    endtask

    task automatic test_single();
        bit ok;
        reset_and_release();
        q.push_back(mk(16'd7, 1'b1));
        send_job(64'h1234, 1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_accept: timeout, required acceptance"); end
        checks++;
        if (solver_start !== 4'b0001 || solver_job[JW-1:0] !== 64'h1234) begin
            errors++;
            $display("FAIL single_start: start=%b job0=%h, required 0001/1234", solver_start, solver_job[JW-1:0]);
        end
        checks++;
        if (job_ready !== 1'b0 || busy_count !== 3'd1) begin
            errors++;
            $display("FAIL single_ready: job_ready=%b busy=%0d, required 0/1", job_ready, busy_count);
        end
        repeat (4) step();
        checks++;
        if (res_valid !== 1'b0 || solver_start !== 4'b0000) begin
            errors++;
            $display("FAIL single_early: res_valid=%b start=%b, required 0/0000", res_valid, solver_start);
        end
        man_result[RW-1:0] = 16'd7;
        man_done = 4'b0001;
        step();
        man_done = '0;
        checks++;
        if (res_valid !== 1'b1 || res_data !== q[0].data || res_last !== q[0].last) begin
            errors++;
            $display("FAIL single_result: v=%b data=%0d last=%b, required 1/%0d/%b", res_valid, res_data, res_last, q[0].data, q[0].last);
        end
        res_ready = 1'b1;
        void'(q.pop_front());
        step();
        res_ready = 1'b0;
        checks++;
        if (all_done !== 1'b1 || busy_count !== 3'd0 || res_valid !== 1'b0 || job_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_retire: all_done=%b busy=%0d v=%b ready=%b, required 1/0/0/0", all_done, busy_count, res_valid, job_ready);
        end
    endtask

    task automatic test_out_of_order();
        bit ok;
        int got;
        int order [4] = '{2, 3, 0, 1};
        logic [RW-1:0] vals [4] = '{16'd3, 16'd5, 16'd2, 16'd9};
        exp_t e;
        reset_and_release();
        for (int k = 0; k < 4; k++) begin
            q.push_back(mk(vals[k], k == 3));
            send_job(64'(k + 1), k == 3, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL ooo_accept%0d: timeout, required acceptance", k); end
        end
        checks++;
        if (busy_count !== 3'd4 || job_ready !== 1'b0) begin
            errors++;
            $display("FAIL ooo_full: busy=%0d ready=%b, required 4/0", busy_count, job_ready);
        end
        step();
        for (int j = 0; j < 4; j++) begin
            man_result[order[j]*RW +: RW] = vals[order[j]];
            man_done = '0;
            man_done[order[j]] = 1'b1;
            step();
            man_done = '0;
            if (j < 2) begin
                checks++;
                if (res_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL ooo_hold%0d: res_valid=%b, required 0", j, res_valid);
                end
            end
        end
        res_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            if (res_valid) begin
                e = q.pop_front();
                checks++;
                if (res_data !== e.data || res_last !== e.last) begin
                    errors++;
                    $display("FAIL ooo_order%0d: data=%0d last=%b, required %0d/%b", got, res_data, res_last, e.data, e.last);
                end
                got++;
            end
            step();
        end
        res_ready = 1'b0;
        checks++;
        if (got != 4 || all_done !== 1'b1) begin
            errors++;
            $display("FAIL ooo_count: got=%0d all_done=%b, required 4/1", got, all_done);
        end
    endtask

    task automatic test_full();
        bit ok;
        int got;
        exp_t e;
        reset_and_release();
        for (int k = 0; k < 4; k++) begin
            q.push_back(mk(16'(10 + k), 1'b0));
            send_job(64'(256 + k), 1'b0, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL full_accept%0d: timeout, required acceptance", k); end
        end
        step();
        for (int i = 0; i < 4; i++) man_result[i*RW +: RW] = 16'(10 + i);
        man_done = 4'b1111;
        step();
        man_done = '0;
        step();
        checks++;
        if (job_ready !== 1'b0 || busy_count !== 3'd4 || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_state: ready=%b busy=%0d v=%b, required 0/4/1", job_ready, busy_count, res_valid);
        end
        job_data = 64'h55;
        job_last = 1'b1;
        job_valid = 1'b1;
        step();
        checks++;
        if (job_ready !== 1'b0 || solver_start !== 4'b0000) begin
            errors++;
            $display("FAIL full_blocked: ready=%b start=%b, required 0/0000", job_ready, solver_start);
        end
        res_ready = 1'b1;
        e = q.pop_front();
        checks++;
        if (res_data !== e.data) begin
            errors++;
            $display("FAIL full_head: data=%0d, required %0d", res_data, e.data);
        end
        step();
        res_ready = 1'b0;
        checks++;
        if (job_ready !== 1'b1 || busy_count !== 3'd3 || solver_start !== 4'b0000) begin
            errors++;
            $display("FAIL full_bubble: ready=%b busy=%0d start=%b, required 1/3/0000", job_ready, busy_count, solver_start);
        end
        q.push_back(mk(16'h66, 1'b1));
        step();
        job_valid = 1'b0;
        job_last = 1'b0;
        checks++;
        if (solver_start !== 4'b0001 || solver_job[JW-1:0] !== 64'h55 || busy_count !== 3'd4 || job_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_wrap: start=%b job0=%h busy=%0d ready=%b, required 0001/55/4/0", solver_start, solver_job[JW-1:0], busy_count, job_ready);
        end
        step();
        man_result[RW-1:0] = 16'h66;
        man_done = 4'b0001;
        step();
        man_done = '0;
        res_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            if (res_valid) begin
                e = q.pop_front();
                checks++;
                if (res_data !== e.data || res_last !== e.last) begin
                    errors++;
                    $display("FAIL full_drain%0d: data=%0d last=%b, required %0d/%b", got, res_data, res_last, e.data, e.last);
                end
                got++;
            end
            step();
        end
        res_ready = 1'b0;
        checks++;
        if (got != 4 || all_done !== 1'b1) begin
            errors++;
            $display("FAIL full_count: got=%0d all_done=%b, required 4/1", got, all_done);
        end
    endtask

    task automatic test_spurious();
        bit ok;
        reset_and_release();
        man_result[2*RW +: RW] = 16'hBEEF;
        man_done = 4'b0100;
        step();
        man_done = '0;
        checks++;
        if (protocol_err !== 1'b1 || busy_count !== 3'd0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL spur_flag: err=%b busy=%0d v=%b, required 1/0/0", protocol_err, busy_count, res_valid);
        end
        q.push_back(mk(16'h21, 1'b1));
        send_job(64'h21, 1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL spur_accept: timeout, required acceptance"); end
        step();
        man_result[RW-1:0] = 16'h21;
        man_done = 4'b0001;
        step();
        man_done = '0;
        checks++;
        if (res_valid !== 1'b1 || res_data !== q[0].data || res_last !== q[0].last) begin
            errors++;
            $display("FAIL spur_result: v=%b data=%h last=%b, required 1/%h/%b", res_valid, res_data, res_last, q[0].data, q[0].last);
        end
        void'(q.pop_front());
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checks++;
        if (all_done !== 1'b1 || protocol_err !== 1'b1) begin
            errors++;
            $display("FAIL spur_sticky: all_done=%b err=%b, required 1/1", all_done, protocol_err);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [N*JW-1:0] exp_job;
        reset_and_release();
        for (int k = 0; k < 3; k++) begin
            send_job(64'(k + 77), 1'b0, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL mid_accept%0d: timeout, required acceptance", k); end
        end
        checks++;
        if (busy_count !== 3'd3) begin
            errors++;
            $display("FAIL mid_busy: busy=%0d, required 3", busy_count);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({job_ready, solver_start, res_valid, res_last, all_done, protocol_err} !== 9'd0 ||
            solver_job !== {(N*JW){1'b0}} || res_data !== 16'h0000 || busy_count !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset: ready=%b start=%b v=%b busy=%0d job=%h, required all zero", job_ready, solver_start, res_valid, busy_count, solver_job);
        end
        rst = 1'b0;
        q.delete();
        step();
        send_job(64'hABCD, 1'b0, ok);
        exp_job = '0;
        exp_job[JW-1:0] = 64'hABCD;
        checks++;
        if (!ok || solver_start !== 4'b0001 || solver_job !== exp_job) begin
            errors++;
            $display("FAIL mid_redispatch: ok=%b start=%b job=%h, required 1/0001/%h", ok, solver_start, solver_job, exp_job);
        end
    endtask

    task automatic test_stream();
        int got;
        bit drv_ok;
        exp_t e;
        reset_and_release();
        auto_mode = 1'b1;
        got = 0;
        drv_ok = 1'b1;
        fork
            begin
                bit ok;
                logic [JW-1:0] d;
                for (int k = 0; k < 10; k++) begin
                    d = {32'($urandom), 16'($urandom), 16'(k * 37 + 1)};
                    q.push_back(mk(model_result(d), k == 9));
                    send_job(d, k == 9, ok);
                    if (!ok) drv_ok = 1'b0;
                end
            end
            begin
                for (int c = 0; c < 2000 && got < 10; c++) begin
                    res_ready = 1'($urandom_range(1, 0));
                    if (res_valid && res_ready) begin
                        checks++;
                        if (q.size() == 0) begin
                            errors++;
                            $display("FAIL stream_extra: unexpected result %h", res_data);
                        end else begin
                            e = q.pop_front();
                            if (res_data !== e.data || res_last !== e.last) begin
                                errors++;
                                $display("FAIL stream_res%0d: data=%h last=%b, required %h/%b", got, res_data, res_last, e.data, e.last);
                            end
                        end
                        got++;
                    end
                    step();
                end
                res_ready = 1'b0;
            end
        join
        checks++;
        if (!drv_ok || got != 10) begin
            errors++;
            $display("FAIL stream_count: driver_ok=%b got=%0d, required 1/10", drv_ok, got);
        end
        step();
        checks++;
        if (all_done !== 1'b1 || busy_count !== 3'd0 || res_valid !== 1'b0 || protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: all_done=%b busy=%0d v=%b err=%b, required 1/0/0/0", all_done, busy_count, res_valid, protocol_err);
        end
        auto_mode = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        job_valid = 1'b0;
        job_data = '0;
        job_last = 1'b0;
        res_ready = 1'b0;
        test_reset();
        test_single();
        test_out_of_order();
        test_full();
        test_spurious();
        test_reset_mid();
        test_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
